chacha_keystream_gen: RTL

- Parametrised successor to the block-function-plus-serialiser pairing.
- Drives ChaCha20 block-function requests with an auto-incrementing 32-bit block counter.
- Double/multi-buffers returned 16-word blocks and streams keystream as OUT_WIDTH-bit beats on a valid/ready interface, RFC 8439 byte order.
- Supports arbitrary byte lengths with a partial last beat. Sits between the block function and the Poly1305/XOR datapath.

---
 rtl/chacha_pkg.sv | 14 +
 rtl/chacha_keystream_gen_if.sv | 26 ++
 rtl/chacha_keystream_gen_ks_block_buffer.sv | 75 +++++++
 rtl/chacha_keystream_gen.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/chacha_pkg.sv
// Shared ChaCha20 keystream types: 32-bit words, 16-word blocks, block geometry.
package chacha_pkg;

    localparam int unsigned WORD_W      = 32;
    localparam int unsigned BLOCK_WORDS = 16;
    localparam int unsigned BLOCK_BYTES = 64;
    localparam int unsigned BLOCK_BITS  = BLOCK_BYTES * 8;
    localparam int unsigned CTR_W       = 32;

    typedef logic [WORD_W-1:0] word_t;
    // Word 0 occupies bits [31:0], so the flattened block is already in keystream byte order.
    typedef word_t [BLOCK_WORDS-1:0] block_t;

endpackage

// File: rtl/chacha_keystream_gen_if.sv
// Keystream valid/ready beat interface between the generator and the XOR/Poly1305 datapath.
interface chacha_keystream_gen_if #(
    parameter int unsigned OUT_WIDTH = 32
);
    logic [OUT_WIDTH-1:0]   ks_data;
    logic [OUT_WIDTH/8-1:0] ks_keep;
    logic                   ks_valid;
    logic                   ks_ready;
    logic                   ks_last;

    modport master (
        output ks_data,
        output ks_keep,
        output ks_valid,
        output ks_last,
        input  ks_ready
    );

    modport slave (
        input  ks_data,
        input  ks_keep,
        input  ks_valid,
        input  ks_last,
        output ks_ready
    );
endinterface

// File: rtl/chacha_keystream_gen_ks_block_buffer.sv
// Ring of NUM_BUFS 512-bit keystream blocks with occupancy tracking and beat-select mux.
module ks_block_buffer
    import chacha_pkg::*;
#(
    parameter int unsigned OUT_WIDTH = 32,
    parameter int unsigned NUM_BUFS  = 2,
    parameter int unsigned BEAT_W    = $clog2(BLOCK_BITS / OUT_WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  block_t               wr_block,
    input  logic                 rd_free,
    input  logic [BEAT_W-1:0]    beat_idx,
    output logic                 full,
    output logic                 valid,
    output logic [OUT_WIDTH-1:0] beat_data
);

    localparam int unsigned PTR_W = (NUM_BUFS > 1) ? $clog2(NUM_BUFS) : 1;
    localparam int unsigned OCC_W = $clog2(NUM_BUFS + 1);
    localparam int unsigned IDX_W = $clog2(BLOCK_BITS);
    localparam int unsigned SEL_SHIFT = $clog2(OUT_WIDTH);

    block_t                 mem [NUM_BUFS];
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;
    logic [OCC_W-1:0]       occ;
    logic [OCC_W-1:0]       occ_next;
    logic [BLOCK_BITS-1:0]  cur;
    logic [IDX_W-1:0]       sel_base;

    // Simultaneous fill and free leave occupancy unchanged.
    always_comb begin
        occ_next = occ;
        case ({wr_en, rd_free})
            2'b10:   occ_next = occ + OCC_W'(1);
            2'b01:   occ_next = occ - OCC_W'(1);
            default: occ_next = occ;
        endcase
        full = (occ == OCC_W'(NUM_BUFS));
    end

    always_comb begin
        cur       = mem[rd_ptr];
        sel_base  = IDX_W'(beat_idx) << SEL_SHIFT;
        beat_data = cur[sel_base +: OUT_WIDTH];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
            valid  <= 1'b0;
        end else begin
            occ   <= occ_next;
            valid <= (occ_next != '0);
            if (wr_en) begin
                wr_ptr <= (wr_ptr == PTR_W'(NUM_BUFS - 1)) ? '0 : wr_ptr + PTR_W'(1);
            end
            if (rd_free) begin
                rd_ptr <= (rd_ptr == PTR_W'(NUM_BUFS - 1)) ? '0 : rd_ptr + PTR_W'(1);
            end
        end
    end

    // Block storage is pure datapath; readers only look at it while valid is set.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= wr_block;
        end
    end

endmodule

// File: rtl/chacha_keystream_gen.sv
// Requests ChaCha20 blocks with an incrementing counter and streams them as keystream beats.
module chacha_keystream_gen
    import chacha_pkg::*;
#(
    parameter int unsigned OUT_WIDTH = 32,
    parameter int unsigned NUM_BUFS  = 2,
    parameter int unsigned LEN_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CTR_W-1:0] init_counter,
    input  logic [LEN_W-1:0] num_bytes,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic             bf_start,
    output logic [CTR_W-1:0] bf_counter,
    input  logic             bf_done,
    input  block_t           bf_block,
    chacha_keystream_gen_if.master ks
);

    localparam int unsigned BYTES     = OUT_WIDTH / 8;
    localparam int unsigned BEATS     = BLOCK_BYTES / BYTES;
    localparam int unsigned BEAT_W    = $clog2(BEATS);
    localparam int unsigned BLK_W     = LEN_W - 5;
    localparam int unsigned BLK_SHIFT = $clog2(BLOCK_BYTES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_FIN
    } state_t;

    state_t               state;
    logic [CTR_W-1:0]     counter;
    logic [BLK_W-1:0]     blocks_left;
    logic [LEN_W-1:0]     bytes_left;
    logic [BEAT_W-1:0]    beat_idx;

    logic                 buf_full;
    logic                 buf_valid;
    logic [OUT_WIDTH-1:0] beat_data;
    logic                 buf_wr;
    logic                 buf_free;
    logic                 fire;
    logic                 last_beat;
    logic [BYTES-1:0]     keep_mask;
    logic [BLK_W-1:0]     blocks_needed;
    logic [CTR_W:0]       end_counter;

    always_comb begin
        blocks_needed = BLK_W'(({1'b0, num_bytes} + (LEN_W + 1)'(BLOCK_BYTES - 1)) >> BLK_SHIFT);
        end_counter   = {1'b0, init_counter} + (CTR_W + 1)'(blocks_needed) - (CTR_W + 1)'(1);
        last_beat     = (bytes_left <= LEN_W'(BYTES));
        keep_mask     = ~({BYTES{1'b1}} << bytes_left);
        fire          = buf_valid && ks.ks_ready;
        // The last beat frees its buffer early, discarding the unused tail of a partial block.
        buf_free      = fire && (last_beat || (beat_idx == BEAT_W'(BEATS - 1)));
        buf_wr        = (state == S_WAIT) && bf_done;
    end

    ks_block_buffer #(
        .OUT_WIDTH (OUT_WIDTH),
        .NUM_BUFS  (NUM_BUFS),
        .BEAT_W    (BEAT_W)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (buf_wr),
        .wr_block  (bf_block),
        .rd_free   (buf_free),
        .beat_idx  (beat_idx),
        .full      (buf_full),
        .valid     (buf_valid),
        .beat_data (beat_data)
    );

    // Beat fields are decoded from registered buffer state only, so they hold while stalled.
    assign ks.ks_valid = buf_valid;
    assign ks.ks_data  = buf_valid ? beat_data : '0;
    assign ks.ks_last  = buf_valid && last_beat;
    assign ks.ks_keep  = buf_valid ? (last_beat ? keep_mask : '1) : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            bf_start    <= 1'b0;
            bf_counter  <= '0;
            counter     <= '0;
            blocks_left <= '0;
            bytes_left  <= '0;
            beat_idx    <= '0;
        end else begin
            done     <= 1'b0;
            err      <= 1'b0;
            bf_start <= 1'b0;

            if (fire) begin
                beat_idx   <= buf_free ? '0 : beat_idx + BEAT_W'(1);
                bytes_left <= last_beat ? '0 : bytes_left - LEN_W'(BYTES);
            end

            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (num_bytes == '0) begin
                            done <= 1'b1;
                        end else if (end_counter[CTR_W]) begin
                            err <= 1'b1;
                        end else begin
                            busy        <= 1'b1;
                            state       <= S_ISSUE;
                            counter     <= init_counter;
                            blocks_left <= blocks_needed;
                            bytes_left  <= num_bytes;
                        end
                    end
                end
                S_ISSUE: begin
                    if (blocks_left == '0) begin
                        state <= S_FIN;
                    end else if (!buf_full || buf_free) begin
                        bf_start   <= 1'b1;
                        bf_counter <= counter;
                        state      <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (bf_done) begin
                        counter     <= counter + CTR_W'(1);
                        blocks_left <= blocks_left - BLK_W'(1);
                        state       <= S_ISSUE;
                    end
                end
                S_FIN: begin
                    state <= S_FIN;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase

            // A short final block can drain before the request side reaches FIN.
            if (fire && last_beat) begin
                done  <= 1'b1;
                busy  <= 1'b0;
                state <= S_IDLE;
            end
        end
    end

endmodule
